// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous memory between instruction fetch and load/store.
// Data wins contention unless fetch has waited MAX_DSTREAK data grants; one read in flight at a time.
module mem_arbiter #(
  parameter int         MEM_LAT     = 1,
  parameter int         MAX_DSTREAK = 4,
  parameter logic [2:0] IF_RD_CTRL  = 3'b010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_rd_ctrl,
  input  logic [1:0]  d_wr_ctrl,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [2:0]  m_rd_ctrl,
  output logic [1:0]  m_wr_ctrl,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic        en;
    logic        we;
    logic [2:0]  rd_ctrl;
    logic [1:0]  wr_ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  localparam logic [2:0] LAT  = 3'(MEM_LAT);
  localparam logic [3:0] DMAX = 4'(MAX_DSTREAK);

  state_t     state;
  logic [2:0] cnt;
  logic [3:0] dstreak;
  logic       owner;
  logic       sel_d, sel_i;
  mem_cmd_t   cmd;

  // Grants are combinational and gated by reset so a grant never coincides with rst.
  always_comb begin
    sel_d = 1'b0;
    sel_i = 1'b0;
    if (!rst && state == IDLE) begin
      sel_d = d_req && !(if_req && dstreak == DMAX);
      sel_i = if_req && !sel_d;
    end
  end

  always_comb begin
    cmd = '0;
    if (sel_d) begin
      cmd.en      = 1'b1;
      cmd.we      = d_we;
      cmd.rd_ctrl = d_rd_ctrl;
      cmd.wr_ctrl = d_wr_ctrl;
      cmd.addr    = d_addr;
      cmd.wdata   = d_wdata;
    end else if (sel_i) begin
      cmd.en      = 1'b1;
      cmd.rd_ctrl = IF_RD_CTRL;
      cmd.addr    = if_addr;
    end
  end

  assign if_gnt    = sel_i;
  assign d_gnt     = sel_d;
  assign m_en      = cmd.en;
  assign m_we      = cmd.we;
  assign m_rd_ctrl = cmd.rd_ctrl;
  assign m_wr_ctrl = cmd.wr_ctrl;
  assign m_addr    = cmd.addr;
  assign m_wdata   = cmd.wdata;
  assign busy      = (state == WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dstreak   <= '0;
      owner     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_i) begin
            dstreak <= '0;
            state   <= WAIT;
            cnt     <= LAT;
            owner   <= 1'b0;
          end else if (sel_d) begin
            // Streak only counts data grants that actually made a fetch wait.
            if (if_req && dstreak < DMAX) dstreak <= dstreak + 4'd1;
            if (!d_we) begin
              state <= WAIT;
              cnt   <= LAT;
              owner <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt > 3'd1) begin
            cnt <= cnt - 3'd1;
          end else begin
            if (owner) begin
              d_rdata  <= m_rdata;
              d_rvalid <= 1'b1;
            end else begin
              if_rdata  <= m_rdata;
              if_rvalid <= 1'b1;
            end
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
